sub1_host: RTL and testbench
============================

Name: sub1_host

Overview:
- Host-side counterpart to the sub1 interface.
- Packs a byte stream into the 3-entry packed and unpacked arrays that sub1 consumes, and fires a request strobe with a 2-bit tag.
- Waits for sub1's response, captures the response vector and arrays, and serialises them back out as a byte stream.
- Sits between a byte-wide command source and sub1; includes a timeout so a missing response never hangs the host.

Parameters:
- TIMEOUT, 15, number of WAIT cycles without i_sig_e before abort; legal range 1..255; counter is 8 bits.

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  reset: synchronous, active-high
- i_in_valid  input  1  command byte valid
- i_in_data  input  [7:0]  command byte
- o_in_ready  output  1  command byte accepted when valid && ready
- o_sig_a  output  1  request strobe, 1-cycle pulse
- o_sig_b  output  [1:0]  request tag
- o_sig_c  output  [0:2][7:0]  packed request array
- o_sig_d  output  [7:0] [0:2] unpacked request array
- i_sig_e  input  1  response strobe
- i_sig_f  input  [1:0]  response status
- i_sig_g  input  [0:2][7:0]  packed response array
- i_sig_h  input  [7:0] [0:2] unpacked response array
- o_rsp_valid  output  1  response byte valid
- o_rsp_data  output  [7:0]  response byte
- o_rsp_last  output  1  final response byte (byte 6)
- i_rsp_ready  input  1  response byte consumed when valid && ready
- o_timeout  output  1  1-cycle pulse on timeout abort
- o_busy  output  1  high in ISSUE, WAIT and SEND

Behaviour:
- Reset (synchronous, any state):
  - State goes to LOAD; byte index, tag and timeout counter go to 0.
  - o_sig_c and all o_sig_d entries go to 0; the response capture register is cleared.
  - o_sig_a, o_rsp_valid, o_rsp_last, o_timeout and o_busy go to 0.
  - o_in_ready goes to 1 the cycle after reset deasserts.
  - Any partially loaded command is discarded.
- State LOAD:
  - o_in_ready=1.
  - Accepted byte k (k=0,1,2) writes o_sig_c[k]=byte and o_sig_d[2-k]=byte (reversed order).
  - Accepting k=2 goes to ISSUE.
  - o_sig_c and o_sig_d hold their values until the next LOAD overwrites them.
- State ISSUE:
  - Lasts exactly 1 cycle: o_sig_a=1 and o_sig_b=tag; the tag is latched as the issued tag.
  - Tag increments mod 4 on leaving ISSUE (3 wraps to 0).
  - Timeout counter is cleared; next state is WAIT.
- State WAIT:
  - i_sig_e is sampled only in WAIT; a high in ISSUE or LOAD is ignored.
  - If i_sig_e=1, capture i_sig_f, i_sig_g[0..2] and i_sig_h[0..2], then go to SEND.
  - Otherwise the counter increments. When the counter reaches TIMEOUT, pulse o_timeout for 1 cycle, go to LOAD with the byte index at 0, and keep the tag already advanced.
  - If i_sig_e=1 in the same cycle the counter would expire, the response wins and no timeout occurs.
- State SEND: 7 bytes, in this order:
  - b0 = {4'b0, issued_tag, f}
  - b1..b3 = g[0], g[1], g[2]
  - b4..b6 = h[0], h[1], h[2]
- Response stream rules:
  - o_rsp_valid=1 throughout SEND.
  - o_rsp_data and o_rsp_last stay stable while valid && !ready.
  - The byte advances only on handshake.
  - o_rsp_last=1 only with b6; accepting b6 goes to LOAD.
- Latency:
  - Third command byte accepted at cycle N gives o_sig_a=1 at N+1.
  - If i_sig_e=1 at N+2, o_rsp_valid=1 with b0 at N+3.
  - With i_rsp_ready held high, the last byte is accepted at N+9 and o_in_ready=1 at N+10.
- o_in_ready=0 in every state except LOAD; there is no command buffering.

Test Plan:
- Reset then bytes 0x11, 0x22, 0x33 -> o_sig_c = {0x11, 0x22, 0x33}; o_sig_d[0..2] = 0x33, 0x22, 0x11; o_sig_a pulses 1 cycle with o_sig_b=0 at N+1.
- Response: i_sig_e=1 at N+2 with f=2'b10, g={0xA0, 0xA1, 0xA2}, h={0xB0, 0xB1, 0xB2}; i_rsp_ready=1 -> bytes 0x02, A0, A1, A2, B0, B1, B2 on consecutive cycles; o_rsp_last only on B2.
- Backpressure: i_rsp_ready toggled 0/1 each cycle -> no byte lost or repeated; data stable while stalled; 7 bytes total.
- Timeout: TIMEOUT=4, i_sig_e never asserted -> o_timeout pulses exactly 4 cycles after o_sig_a, o_in_ready=1 the next cycle; next request carries o_sig_b=1.
- Tag wrap and edge case: five back-to-back transactions -> tags 0, 1, 2, 3, 0 appear in b0[3:2]. i_sig_e raised in the expiry cycle -> response captured, no o_timeout.
- Mid-operation reset: assert i_rst during SEND after b2 -> next cycle all outputs are at reset values and the tag is 0. A new command then produces o_sig_b=0 and a fresh array load.

Source files
------------

// File: rtl/sub1_host.sv
// sub1_host: host-side bridge for the sub1 interface.
// Collects three command bytes into the packed/unpacked request arrays,
// issues a tagged request strobe, waits (with timeout) for sub1's response,
// then streams the captured response back out as seven bytes.
module sub1_host #(
    parameter int TIMEOUT = 15
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    input  logic [7:0]       i_in_data,
    output logic             o_in_ready,
    output logic             o_sig_a,
    output logic [1:0]       o_sig_b,
    output logic [0:2][7:0]  o_sig_c,
    output logic [7:0]       o_sig_d [0:2],
    input  logic             i_sig_e,
    input  logic [1:0]       i_sig_f,
    input  logic [0:2][7:0]  i_sig_g,
    input  logic [7:0]       i_sig_h [0:2],
    output logic             o_rsp_valid,
    output logic [7:0]       o_rsp_data,
    output logic             o_rsp_last,
    input  logic             i_rsp_ready,
    output logic             o_timeout,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SEND  = 2'd3
    } state_e;

    // Counter value whose next increment reaches TIMEOUT.
    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);
    localparam logic [2:0] LAST_IDX   = 3'd6;

    state_e          state_q, state_d;
    logic [1:0]      ld_idx_q, ld_idx_d;
    logic [1:0]      tag_q, tag_d;
    logic [1:0]      sig_b_q, sig_b_d;      // doubles as the issued tag
    logic [7:0]      cnt_q, cnt_d;
    logic [0:2][7:0] sig_c_q, sig_c_d;
    logic [7:0]      sig_d_q [0:2];
    logic [7:0]      sig_d_d [0:2];
    logic [0:6][7:0] rsp_buf_q, rsp_buf_d;
    logic [2:0]      rsp_idx_q, rsp_idx_d;

    logic            in_ready_q, in_ready_d;
    logic            sig_a_q, sig_a_d;
    logic            busy_q, busy_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_last_q, rsp_last_d;
    logic [7:0]      rsp_data_q, rsp_data_d;

    logic            in_accept_s;
    logic            rsp_hs_s;
    logic            expire_s;

    assign in_accept_s = i_in_valid && in_ready_q;
    assign rsp_hs_s    = rsp_valid_q && i_rsp_ready;
    assign expire_s    = (cnt_q == TIMEOUT_M1);

    // Next-state logic for the transaction sequencer and its datapath.
    always_comb begin
        state_d   = state_q;
        ld_idx_d  = ld_idx_q;
        tag_d     = tag_q;
        sig_b_d   = sig_b_q;
        cnt_d     = cnt_q;
        sig_c_d   = sig_c_q;
        sig_d_d   = sig_d_q;
        rsp_buf_d = rsp_buf_q;
        rsp_idx_d = rsp_idx_q;

        case (state_q)
            ST_LOAD: begin
                if (in_accept_s) begin
                    // Packed array fills forward, unpacked array fills reversed.
                    sig_c_d[ld_idx_q]        = i_in_data;
                    sig_d_d[2'd2 - ld_idx_q] = i_in_data;
                    if (ld_idx_q == 2'd2) begin
                        ld_idx_d = 2'd0;
                        sig_b_d  = tag_q;
                        state_d  = ST_ISSUE;
                    end else begin
                        ld_idx_d = ld_idx_q + 2'd1;
                    end
                end else begin
                    ld_idx_d = ld_idx_q;
                end
            end
            ST_ISSUE: begin
                tag_d   = tag_q + 2'd1;
                cnt_d   = 8'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_sig_e) begin
                    // A response in the expiry cycle still wins over the timeout.
                    rsp_buf_d[0] = {4'b0000, sig_b_q, i_sig_f};
                    rsp_buf_d[1] = i_sig_g[0];
                    rsp_buf_d[2] = i_sig_g[1];
                    rsp_buf_d[3] = i_sig_g[2];
                    rsp_buf_d[4] = i_sig_h[0];
                    rsp_buf_d[5] = i_sig_h[1];
                    rsp_buf_d[6] = i_sig_h[2];
                    rsp_idx_d    = 3'd0;
                    state_d      = ST_SEND;
                end else if (expire_s) begin
                    cnt_d    = cnt_q + 8'd1;
                    ld_idx_d = 2'd0;
                    state_d  = ST_LOAD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_SEND: begin
                if (rsp_hs_s) begin
                    if (rsp_idx_q == LAST_IDX) begin
                        rsp_idx_d = 3'd0;
                        state_d   = ST_LOAD;
                    end else begin
                        rsp_idx_d = rsp_idx_q + 3'd1;
                    end
                end else begin
                    rsp_idx_d = rsp_idx_q;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Output values for the next cycle, derived from the next state so that
    // every handshake/strobe output leaves a flop.
    always_comb begin
        in_ready_d  = (state_d == ST_LOAD);
        sig_a_d     = (state_d == ST_ISSUE);
        busy_d      = (state_d != ST_LOAD);
        rsp_valid_d = (state_d == ST_SEND);
        if (state_d == ST_SEND) begin
            rsp_data_d = rsp_buf_d[rsp_idx_d];
            rsp_last_d = (rsp_idx_d == LAST_IDX);
        end else begin
            rsp_data_d = 8'h00;
            rsp_last_d = 1'b0;
        end
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_LOAD;
            ld_idx_q    <= 2'd0;
            tag_q       <= 2'd0;
            sig_b_q     <= 2'd0;
            cnt_q       <= 8'd0;
            sig_c_q     <= '{default: 8'h00};
            sig_d_q     <= '{default: 8'h00};
            rsp_buf_q   <= '{default: 8'h00};
            rsp_idx_q   <= 3'd0;
            in_ready_q  <= 1'b0;
            sig_a_q     <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            ld_idx_q    <= ld_idx_d;
            tag_q       <= tag_d;
            sig_b_q     <= sig_b_d;
            cnt_q       <= cnt_d;
            sig_c_q     <= sig_c_d;
            sig_d_q     <= sig_d_d;
            rsp_buf_q   <= rsp_buf_d;
            rsp_idx_q   <= rsp_idx_d;
            in_ready_q  <= in_ready_d;
            sig_a_q     <= sig_a_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // The abort pulse must react to i_sig_e in the expiry cycle itself.
    assign o_timeout   = (state_q == ST_WAIT) && !i_sig_e && expire_s && !i_rst;

    assign o_in_ready  = in_ready_q;
    assign o_sig_a     = sig_a_q;
    assign o_sig_b     = sig_b_q;
    assign o_sig_c     = sig_c_q;
    assign o_sig_d     = sig_d_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_last  = rsp_last_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_sub1_host.sv
// Testbench for sub1_host: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_sub1_host;

    localparam int TO = 4;
    localparam int M_LOAD = 0, M_ISSUE = 1, M_WAIT = 2, M_SEND = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [7:0]      in_data;
    logic            in_ready;
    logic            sig_a;
    logic [1:0]      sig_b;
    logic [0:2][7:0] sig_c;
    logic [7:0]      sig_d [0:2];
    logic            sig_e;
    logic [1:0]      sig_f;
    logic [0:2][7:0] sig_g;
    logic [7:0]      sig_h [0:2];
    logic            rsp_valid;
    logic [7:0]      rsp_data;
    logic            rsp_last;
    logic            rsp_ready;
    logic            timeout;
    logic            busy;

    always #5 clk = ~clk;

    sub1_host #(.TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready),
        .o_sig_a(sig_a), .o_sig_b(sig_b), .o_sig_c(sig_c), .o_sig_d(sig_d),
        .i_sig_e(sig_e), .i_sig_f(sig_f), .i_sig_g(sig_g), .i_sig_h(sig_h),
        .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_rsp_last(rsp_last),
        .i_rsp_ready(rsp_ready), .o_timeout(timeout), .o_busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model: what the host is doing, in transaction terms.
    int         m_mode = M_LOAD;
    int         m_nb = 0;
    int         m_cnt = 0;
    logic [1:0] m_tag = 2'd0;
    logic [1:0] m_iss = 2'd0;
    logic [7:0] m_c [0:2];
    logic [7:0] m_q [$];
    bit         m_init = 1'b0;
    bit         m_rst_prev = 1'b1;
    bit         m_acc = 1'b0;

    // Observation log for the literal checks.
    int         sa_cyc = 0, to_cyc = 0, to_cnt = 0, acc_cyc = 0, rv_cyc = 0;
    logic [1:0] sb_seen = 2'd0;
    bit         prev_valid = 1'b0;
    logic [7:0] seen [$];
    bit         seen_last [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        bit e_ready, e_to;
        if (!m_init) return;
        e_ready = (m_mode == M_LOAD) && !m_rst_prev;
        e_to    = (m_mode == M_WAIT) && !sig_e && !rst && (m_cnt == TO - 1);
        chk("in_ready", 32'(in_ready), 32'(e_ready));
        chk("busy", 32'(busy), 32'(m_mode != M_LOAD));
        chk("sig_a", 32'(sig_a), 32'(m_mode == M_ISSUE));
        chk("timeout", 32'(timeout), 32'(e_to));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_mode == M_SEND));
        chk("sig_c", 32'(sig_c), 32'({m_c[0], m_c[1], m_c[2]}));
        for (int k = 0; k < 3; k++) chk("sig_d", 32'(sig_d[k]), 32'(m_c[2-k]));
        if (m_mode == M_ISSUE) chk("sig_b", 32'(sig_b), 32'(m_tag));
        if (m_mode == M_SEND && m_q.size() > 0) begin
            chk("rsp_data", 32'(rsp_data), 32'(m_q[0]));
            chk("rsp_last", 32'(rsp_last), 32'(m_q.size() == 1));
        end
    endtask

    task automatic model_step();
        bit rdy;
        m_acc = 1'b0;
        if (rst) begin
            m_mode = M_LOAD; m_nb = 0; m_cnt = 0; m_tag = 2'd0; m_iss = 2'd0;
            for (int k = 0; k < 3; k++) m_c[k] = 8'h00;
            m_q.delete();
            m_init = 1'b1; m_rst_prev = 1'b1;
            return;
        end
        if (!m_init) return;
        rdy = (m_mode == M_LOAD) && !m_rst_prev;
        m_rst_prev = 1'b0;
        case (m_mode)
            M_LOAD: if (in_valid && rdy) begin
                m_c[m_nb] = in_data;
                m_acc = 1'b1;
                m_nb++;
                if (m_nb == 3) begin m_nb = 0; m_mode = M_ISSUE; acc_cyc = cyc; end
            end
            M_ISSUE: begin
                m_iss = m_tag; m_tag = m_tag + 2'd1; m_cnt = 0; m_mode = M_WAIT;
            end
            M_WAIT: if (sig_e) begin
                m_q.delete();
                m_q.push_back({4'b0000, m_iss, sig_f});
                for (int k = 0; k < 3; k++) m_q.push_back(sig_g[k]);
                for (int k = 0; k < 3; k++) m_q.push_back(sig_h[k]);
                m_mode = M_SEND;
            end else begin
                m_cnt++;
                if (m_cnt == TO) begin m_mode = M_LOAD; m_nb = 0; end
            end
            M_SEND: if (rsp_ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_mode = M_LOAD;
            end
            default: m_mode = M_LOAD;
        endcase
    endtask

    // One clock cycle: inputs already set at the falling edge.
    task automatic tick();
        #1;
        if (sig_a) begin sa_cyc = cyc; sb_seen = sig_b; end
        if (timeout) begin to_cyc = cyc; to_cnt++; end
        if (rsp_valid && !prev_valid) rv_cyc = cyc;
        prev_valid = rsp_valid;
        if (rsp_valid && rsp_ready) begin
            seen.push_back(rsp_data); seen_last.push_back(rsp_last);
        end
        check_outputs();
        model_step();
        cyc++;
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] b [0:2];
        bit got;
        b[0] = b0; b[1] = b1; b[2] = b2;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = b[i]; got = 1'b0;
            for (int w = 0; w < 20 && !got; w++) begin tick(); got = m_acc; end
            if (!got) chk("cmd_accept_bound", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic respond(input logic [1:0] f);
        sig_e = 1'b1; sig_f = f;
        sig_g = 24'($urandom());
        for (int k = 0; k < 3; k++) sig_h[k] = 8'($urandom());
        tick();
        sig_e = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0; tick();
    endtask

    initial begin
        logic [7:0] exp7 [0:6];
        logic [7:0] b;
        int n, lasts, to_snap;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; sig_e = 1'b0; sig_f = 2'b00;
        sig_g = '0; rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) sig_h[k] = 8'h00;
        @(negedge clk);
        tick();
        do_reset();
        chk("reset_ready", 32'(in_ready), 32'd1);
        chk("reset_sig_c", 32'(sig_c), 32'd0);

        // Basic transaction with the documented literal response.
        seen.delete(); seen_last.delete();
        send_cmd(8'h11, 8'h22, 8'h33);
        n = acc_cyc;
        rsp_ready = 1'b1;
        tick();
        sig_e = 1'b1; sig_f = 2'b10; sig_g = 24'hA0A1A2;
        sig_h[0] = 8'hB0; sig_h[1] = 8'hB1; sig_h[2] = 8'hB2;
        tick();
        sig_e = 1'b0;
        repeat (8) tick();
        chk("lit_sig_c", 32'(sig_c), 32'h112233);
        chk("lit_sig_d0", 32'(sig_d[0]), 32'h33);
        chk("lit_sig_d1", 32'(sig_d[1]), 32'h22);
        chk("lit_sig_d2", 32'(sig_d[2]), 32'h11);
        chk("lit_sig_a_latency", 32'(sa_cyc - n), 32'd1);
        chk("lit_sig_b", 32'(sb_seen), 32'd0);
        chk("lit_rsp_latency", 32'(rv_cyc - n), 32'd3);
        exp7[0] = 8'h02; exp7[1] = 8'hA0; exp7[2] = 8'hA1; exp7[3] = 8'hA2;
        exp7[4] = 8'hB0; exp7[5] = 8'hB1; exp7[6] = 8'hB2;
        chk("lit_rsp_count", 32'(seen.size()), 32'd7);
        for (int i = 0; i < 7 && i < seen.size(); i++) begin
            chk("lit_rsp_byte", 32'(seen[i]), 32'(exp7[i]));
            chk("lit_rsp_last", 32'(seen_last[i]), 32'(i == 6));
        end

        // Backpressure: ready toggles every cycle.
        seen.delete(); seen_last.delete();
        send_cmd(8'h44, 8'h55, 8'h66);
        tick();
        respond(2'b01);
        for (int i = 0; i < 30; i++) begin rsp_ready = (cyc % 2 == 0); tick(); end
        rsp_ready = 1'b1;
        lasts = 0;
        foreach (seen_last[i]) lasts += int'(seen_last[i]);
        chk("bp_rsp_count", 32'(seen.size()), 32'd7);
        chk("bp_last_count", 32'(lasts), 32'd1);

        // Timeout with no response, then the next request carries tag 1.
        do_reset();
        to_cnt = 0;
        send_cmd(8'h01, 8'h02, 8'h03);
        repeat (8) tick();
        chk("to_count", 32'(to_cnt), 32'd1);
        chk("to_delay", 32'(to_cyc - sa_cyc), 32'd4);
        send_cmd(8'h04, 8'h05, 8'h06);
        tick();
        chk("to_next_tag", 32'(sb_seen), 32'd1);
        respond(2'b11);
        repeat (8) tick();

        // Five back-to-back transactions: tag wraps 0,1,2,3,0.
        do_reset();
        for (int t = 0; t < 5; t++) begin
            seen.delete(); seen_last.delete();
            send_cmd(8'(t), 8'(t + 16), 8'(t + 32));
            tick();
            respond(2'(t));
            repeat (8) tick();
            if (seen.size() == 0) chk("wrap_no_rsp", 32'd0, 32'd1);
            else begin
                b = seen[0];
                chk("wrap_tag", 32'(b[3:2]), 32'(t % 4));
            end
        end

        // Response arriving in the expiry cycle beats the timeout.
        to_snap = to_cnt;
        seen.delete(); seen_last.delete();
        send_cmd(8'hC0, 8'hC1, 8'hC2);
        tick();
        repeat (TO - 1) tick();
        respond(2'b10);
        repeat (8) tick();
        chk("expiry_no_timeout", 32'(to_cnt), 32'(to_snap));
        chk("expiry_rsp_count", 32'(seen.size()), 32'd7);

        // Reset in the middle of SEND, after b2 has gone.
        send_cmd(8'hD0, 8'hD1, 8'hD2);
        tick();
        respond(2'b00);
        repeat (3) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_last", 32'(rsp_last), 32'd0);
        chk("mid_rst_sig_c", 32'(sig_c), 32'd0);
        chk("mid_rst_sig_d", 32'({sig_d[0], sig_d[1], sig_d[2]}), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        tick();
        send_cmd(8'h77, 8'h88, 8'h99);
        tick();
        chk("mid_rst_tag", 32'(sb_seen), 32'd0);
        chk("mid_rst_sig_c_new", 32'(sig_c), 32'h778899);
        respond(2'b01);
        repeat (8) tick();

        // Random traffic, including strobes outside WAIT and rare resets.
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom());
            sig_e     = ($urandom_range(0, 9) < 3);
            sig_f     = 2'($urandom());
            sig_g     = 24'($urandom());
            for (int k = 0; k < 3; k++) sig_h[k] = 8'($urandom());
            rsp_ready = ($urandom_range(0, 9) < 6);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
